// File: rtl/hall_pkg.sv
// Shared definitions for the hall sensor decoder: sector encoding, direction
// constants and the hall-code to electrical-sector lookup.
package hall_pkg;

    localparam logic [2:0]  SECTOR_INVALID = 3'd7;
    localparam logic        DIR_FWD        = 1'b1;
    localparam logic        DIR_REV        = 1'b0;
    localparam int unsigned NUM_SECTORS    = 6;

    // Forward rotation visits codes 5,4,6,2,3,1; 0 and 7 cannot occur on a healthy sensor set
    function automatic logic [2:0] code_to_sector(input logic [2:0] code);
        logic [2:0] sec;
        case (code)
            3'd5:    sec = 3'd0;
            3'd4:    sec = 3'd1;
            3'd6:    sec = 3'd2;
            3'd2:    sec = 3'd3;
            3'd3:    sec = 3'd4;
            3'd1:    sec = 3'd5;
            default: sec = SECTOR_INVALID;
        endcase
        return sec;
    endfunction

    function automatic logic [2:0] sector_delta(input logic [2:0] old_s, input logic [2:0] new_s);
        logic [3:0] diff;
        diff = 4'(new_s) + 4'(NUM_SECTORS) - 4'(old_s);
        if (diff >= 4'(NUM_SECTORS)) begin
            diff = diff - 4'(NUM_SECTORS);
        end
        return diff[2:0];
    endfunction

endpackage

// File: rtl/hall_filter.sv
// Synchronises the raw 3-bit hall vector and accepts a new code only after it
// has been seen unchanged for FILT_CYCLES consecutive cycles.
module hall_filter
    import hall_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] hall_i,
    output logic [2:0] code_o,
    output logic       accept_c_o,
    output logic [2:0] new_code_c_o
);

    localparam int unsigned    CNT_W  = $clog2(FILT_CYCLES + 1);
    localparam logic [CNT_W:0] FILT_L = (CNT_W + 1)'(FILT_CYCLES);

    logic [2:0]       sync_q [SYNC_STAGES];
    logic [2:0]       s;
    logic [2:0]       code_q, code_d;
    logic [2:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   run_len;
    logic             accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= hall_i;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // A non-zero count means a candidate is being tracked
    always_comb begin
        code_d  = code_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        run_len = (CNT_W + 1)'(1);
        if (cnt_q != '0 && s == cand_q) begin
            run_len = {1'b0, cnt_q} + (CNT_W + 1)'(1);
        end
        if (s == code_q) begin
            cnt_d = '0;
        end else if (run_len >= FILT_L) begin
            accept = 1'b1;
            code_d = s;
            cnt_d  = '0;
        end else begin
            cand_d = s;
            cnt_d  = run_len[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q <= '0;
            cand_q <= '0;
            cnt_q  <= '0;
        end else begin
            code_q <= code_d;
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
        end
    end

    assign code_o       = code_q;
    assign accept_c_o   = accept;
    assign new_code_c_o = s;

endmodule

// File: rtl/hall_decoder.sv
// BLDC hall decoder: filtered code to sector, direction, inter-edge period,
// stall detection and sticky fault flag for illegal codes or skipped sectors.
module hall_decoder
    import hall_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CYCLES = 16,
    parameter int unsigned PERIOD_W    = 24,
    parameter int unsigned TIMEOUT     = 10_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                hall_a_i,
    input  logic                hall_b_i,
    input  logic                hall_c_i,
    input  logic                fault_clr_i,
    output logic [2:0]          hall_code_o,
    output logic [2:0]          sector_o,
    output logic                dir_o,
    output logic                edge_valid_o,
    output logic [PERIOD_W-1:0] period_o,
    output logic                period_valid_o,
    output logic                stalled_o,
    output logic                hall_fault_o
);

    localparam logic [PERIOD_W-1:0] TIMEOUT_L = PERIOD_W'(TIMEOUT);
    localparam logic [PERIOD_W-1:0] CNT_ONE   = PERIOD_W'(1);

    logic                accept;
    logic [2:0]          new_code;
    logic [2:0]          new_sector;
    logic [2:0]          delta;
    logic                legal_c;
    logic                fault_set_c;

    logic [2:0]          sector_q, sector_d;
    logic                dir_q, dir_d;
    logic                locked_q, locked_d;
    logic                ref_q, ref_d;
    logic                edge_q, edge_d;
    logic                pvalid_q, pvalid_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                stalled_q, stalled_d;
    logic                fault_q, fault_d;

    hall_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_CYCLES (FILT_CYCLES)
    ) u_filter (
        .clk          (clk),
        .rst_n        (rst_n),
        .hall_i       ({hall_a_i, hall_b_i, hall_c_i}),
        .code_o       (hall_code_o),
        .accept_c_o   (accept),
        .new_code_c_o (new_code)
    );

    assign new_sector = code_to_sector(new_code);
    assign delta      = sector_delta(sector_q, new_sector);

    // Sector tracking, period measurement, stall and fault handling
    always_comb begin
        sector_d    = sector_q;
        dir_d       = dir_q;
        locked_d    = locked_q;
        ref_d       = ref_q;
        edge_d      = 1'b0;
        pvalid_d    = 1'b0;
        period_d    = period_q;
        cnt_d       = cnt_q;
        stalled_d   = stalled_q;
        fault_d     = fault_q;
        legal_c     = 1'b0;
        fault_set_c = 1'b0;

        if (accept) begin
            if (new_sector == SECTOR_INVALID) begin
                if (locked_q) begin
                    fault_set_c = 1'b1;
                    sector_d    = SECTOR_INVALID;
                    locked_d    = 1'b0;
                    ref_d       = 1'b0;
                end
            end else if (!locked_q) begin
                locked_d = 1'b1;
                sector_d = new_sector;
            end else begin
                sector_d = new_sector;
                if (delta == 3'd1) begin
                    dir_d   = DIR_FWD;
                    legal_c = 1'b1;
                end else if (delta == 3'd5) begin
                    dir_d   = DIR_REV;
                    legal_c = 1'b1;
                end else begin
                    fault_set_c = 1'b1;
                    ref_d       = 1'b0;
                end
            end
        end

        // The edge cycle itself counts as cycle 0 of the next period
        if (legal_c) begin
            edge_d    = 1'b1;
            cnt_d     = CNT_ONE;
            stalled_d = 1'b0;
            ref_d     = 1'b1;
            if (ref_q) begin
                period_d = cnt_q;
                pvalid_d = 1'b1;
            end
        end else begin
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_ONE;
            end
            if (cnt_q == TIMEOUT_L) begin
                stalled_d = 1'b1;
                period_d  = '0;
                ref_d     = 1'b0;
            end
        end

        if (fault_set_c) begin
            fault_d = 1'b1;
        end else if (fault_clr_i) begin
            fault_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sector_q  <= SECTOR_INVALID;
            dir_q     <= DIR_FWD;
            locked_q  <= 1'b0;
            ref_q     <= 1'b0;
            edge_q    <= 1'b0;
            pvalid_q  <= 1'b0;
            period_q  <= '0;
            cnt_q     <= '0;
            stalled_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            sector_q  <= sector_d;
            dir_q     <= dir_d;
            locked_q  <= locked_d;
            ref_q     <= ref_d;
            edge_q    <= edge_d;
            pvalid_q  <= pvalid_d;
            period_q  <= period_d;
            cnt_q     <= cnt_d;
            stalled_q <= stalled_d;
            fault_q   <= fault_d;
        end
    end

    assign sector_o       = sector_q;
    assign dir_o          = dir_q;
    assign edge_valid_o   = edge_q;
    assign period_o       = period_q;
    assign period_valid_o = pvalid_q;
    assign stalled_o      = stalled_q;
    assign hall_fault_o   = fault_q;

endmodule

// File: tb/tb_hall_decoder.sv
// Randomised bench for hall_decoder: a pin-history reference model predicts
// every visible output event; a negedge monitor pops and compares them.
module tb_hall_decoder;

    localparam int SYNC = 2;
    localparam int FILT = 4;
    localparam int TMO  = 1000;
    localparam int PW   = 24;

    typedef struct {
        int         cyc;
        logic [2:0] code;
        logic [2:0] sector;
        logic       dir;
        logic       ev;
        logic       pv;
        logic [PW-1:0] period;
        logic       stalled;
        logic       fault;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          hall_a = 1'b0, hall_b = 1'b0, hall_c = 1'b0;
    logic          fault_clr = 1'b0;
    logic [2:0]    hall_code, sector;
    logic          dir, edge_valid, period_valid, stalled, hall_fault;
    logic [PW-1:0] period;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 0;

    exp_t q[$];
    logic [2:0] hist[$];
    int lut[8]  = '{7, 5, 3, 4, 1, 0, 2, 7};
    int ford[6] = '{5, 4, 6, 2, 3, 1};

    // reference model state
    logic [2:0] m_code = 3'd0;
    int         m_sector = 7;
    logic       m_dir = 1'b1;
    bit         m_locked = 0, m_ref = 0, m_stalled = 0, m_fault = 0;
    int         m_period = 0;
    int         m_last = 1;

    hall_decoder #(
        .SYNC_STAGES (SYNC),
        .FILT_CYCLES (FILT),
        .PERIOD_W    (PW),
        .TIMEOUT     (TMO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .hall_a_i       (hall_a),
        .hall_b_i       (hall_b),
        .hall_c_i       (hall_c),
        .fault_clr_i    (fault_clr),
        .hall_code_o    (hall_code),
        .sector_o       (sector),
        .dir_o          (dir),
        .edge_valid_o   (edge_valid),
        .period_o       (period),
        .period_valid_o (period_valid),
        .stalled_o      (stalled),
        .hall_fault_o   (hall_fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [2:0] hist_at(input int j);
        if (j < 1) return 3'd0;
        return hist[j-1];
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " hall_code"}, int'(hall_code), 0);
        chk({tag, " sector"}, int'(sector), 7);
        chk({tag, " dir"}, int'(dir), 1);
        chk({tag, " edge_valid"}, int'(edge_valid), 0);
        chk({tag, " period"}, int'(period), 0);
        chk({tag, " period_valid"}, int'(period_valid), 0);
        chk({tag, " stalled"}, int'(stalled), 0);
        chk({tag, " hall_fault"}, int'(hall_fault), 0);
    endtask

    // Apply one cycle of pins, predict the result of the coming edge, then wait
    task automatic step(input logic [2:0] code, input logic clr);
        int j0, sec, d, k;
        logic [2:0] x;
        bit acc, legal, fset, st_rise, f_old;
        exp_t e;
        hall_a = code[2]; hall_b = code[1]; hall_c = code[0];
        fault_clr = clr;
        hist.push_back(code);
        k  = hist.size();
        j0 = k - SYNC;
        x  = hist_at(j0);
        acc = (x != m_code) && (hist_at(j0 - FILT) != x);
        for (int i = 0; i < FILT; i++) if (hist_at(j0 - i) != x) acc = 0;
        legal = 0; fset = 0; st_rise = 0; f_old = m_fault;
        if (acc) begin
            m_code = x;
            sec = lut[x];
            if (sec == 7) begin
                if (m_locked) begin fset = 1; m_sector = 7; m_locked = 0; m_ref = 0; end
            end else if (!m_locked) begin
                m_locked = 1; m_sector = sec;
            end else begin
                d = (sec - m_sector + 6) % 6;
                if (d == 1 || d == 5) begin m_dir = (d == 1); legal = 1; end
                else begin fset = 1; m_ref = 0; end
                m_sector = sec;
            end
        end
        e.pv = 0;
        if (legal) begin
            if (m_ref) begin m_period = k - m_last; e.pv = 1; end
            m_ref = 1; m_last = k; m_stalled = 0;
        end else if (k - m_last == TMO) begin
            st_rise = !m_stalled; m_stalled = 1; m_period = 0; m_ref = 0;
        end
        if (fset) m_fault = 1;
        else if (clr) m_fault = 0;
        if (acc || st_rise || m_fault != f_old) begin
            e.cyc = k; e.code = m_code; e.sector = 3'(m_sector); e.dir = m_dir;
            e.ev = legal; e.period = PW'(m_period); e.stalled = m_stalled; e.fault = m_fault;
            q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic [2:0] code, input int hold, input int clr_at);
        for (int i = 0; i < hold; i++) step(code, (i == clr_at));
    endtask

    // Monitor: any visible change or strobe must match the next predicted event
    logic [2:0] p_code = 3'd0;
    logic       p_st = 1'b0, p_f = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            bit active;
            active = (hall_code != p_code) || (stalled != p_st) || (hall_fault != p_f)
                     || edge_valid || period_valid;
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                checks++; errors++;
                $display("FAIL missed_event: cycle %0d expected event never seen", e.cyc);
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                checks++;
                if (hall_code !== e.code || sector !== e.sector || dir !== e.dir ||
                    edge_valid !== e.ev || period_valid !== e.pv || period !== e.period ||
                    stalled !== e.stalled || hall_fault !== e.fault) begin
                    errors++;
                    $display("FAIL event@%0d: got code=%0d sec=%0d dir=%0d ev=%0d pv=%0d per=%0d st=%0d flt=%0d, expected code=%0d sec=%0d dir=%0d ev=%0d pv=%0d per=%0d st=%0d flt=%0d",
                             cyc, hall_code, sector, dir, edge_valid, period_valid, period, stalled, hall_fault,
                             e.code, e.sector, e.dir, e.ev, e.pv, e.period, e.stalled, e.fault);
                end
            end else if (active) begin
                checks++; errors++;
                $display("FAIL unexpected_event@%0d: code=%0d sec=%0d ev=%0d pv=%0d st=%0d flt=%0d",
                         cyc, hall_code, sector, edge_valid, period_valid, stalled, hall_fault);
            end
            p_code = hall_code; p_st = stalled; p_f = hall_fault;
        end
    end

    initial begin
        logic [2:0] cur, nxt;
        int s, r, hr, hold, co;
        repeat (3) @(negedge clk);
        #1 chk_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1;

        drive(3'd5, 10, -1);                                  // acquisition
        foreach (ford[i]) if (i > 0) drive(3'(ford[i]), 200, -1);
        drive(3'd5, 200, -1);                                 // wrap to sector 0
        drive(3'd1, 200, -1);                                 // reverse
        drive(3'd3, 200, -1);
        drive(3'd2, 200, -1);
        drive(3'd6, 200, -1);
        drive(3'd4, 200, -1);
        drive(3'd5, 200, -1);
        drive(3'd4, 3, -1);                                   // short glitch
        drive(3'd5, 200, -1);
        drive(3'd6, 200, -1);                                 // skip: fault
        drive(3'd6, 50, 10);                                  // clear
        drive(3'd3, 200, 5);                                  // clear coincides with new fault
        drive(3'd3, 50, 20);
        drive(3'd1, 200, -1);
        drive(3'd5, 1100, -1);                                // stall
        drive(3'd4, 200, -1);
        drive(3'd7, 200, -1);                                 // illegal while locked
        drive(3'd6, 200, -1);                                 // re-acquire
        drive(3'd2, 200, -1);

        cur = 3'd2;
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            s = lut[cur];
            if (s == 7)      nxt = 3'(ford[$urandom_range(0, 5)]);
            else if (r < 4)  nxt = 3'(ford[(s + 1) % 6]);
            else if (r < 7)  nxt = 3'(ford[(s + 5) % 6]);
            else if (r == 7) nxt = 3'(ford[(s + 2 + int'($urandom_range(0, 2))) % 6]);
            else if (r == 8) nxt = ($urandom_range(0, 1) == 1) ? 3'd0 : 3'd7;
            else             nxt = 3'($urandom_range(0, 7));
            hr = $urandom_range(0, 9);
            if (hr < 3)       hold = $urandom_range(1, 5);
            else if (hr == 9) hold = $urandom_range(990, 1100);
            else              hold = $urandom_range(6, 300);
            co = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, hold - 1)) : -1;
            drive(nxt, hold, co);
            cur = nxt;
        end
        drive(cur, 20, -1);

        chk("pending_events", q.size(), 0);
        mon_en = 0;
        #3 rst_n = 1'b0;
        #1 chk_reset("async_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hall_decoder.md
# hall_decoder

Reads the three raw hall-effect sensor inputs of the BLDC motor and turns them into clean rotor information for the commutation logic and the speed loop. Synchronises and glitch-filters the sensors, maps the hall code to a 0–5 electrical sector, and derives rotation direction. Also measures the inter-edge period in clock cycles, detects stall, and flags illegal codes or skipped sectors. Sits between the hall pins and the commutator/speed controller.

## Interface
- `SYNC_STAGES`, default 2: flip-flop synchroniser depth per hall input (≥2).
- `FILT_CYCLES`, default 16: consecutive stable cycles a new code needs before acceptance (≥1).
- `PERIOD_W`, default 24: width of the period counter and output.
- `TIMEOUT`, default 24'd10_000_000: cycles without an accepted edge before `stalled` asserts (< 2^PERIOD_W).
- `clk` in 1: system clock.
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `hallA`, `hallB`, `hallC` in 1 each: raw asynchronous sensor inputs. Code is {hallA, hallB, hallC}.
- `fault_clr` in 1: single-cycle pulse that clears `hall_fault`.
- `hall_code` out 3: filtered hall code.
- `sector` out 3: electrical sector 0–5. Value 7 means invalid or not yet locked.
- `dir` out 1: 1 = forward (sector +1), 0 = reverse (sector −1).
- `edge_valid` out 1: one-cycle pulse on each accepted legal adjacent-sector step.
- `period` out PERIOD_W: cycles between the last two legal edges.
- `period_valid` out 1: one-cycle pulse when `period` is updated.
- `stalled` out 1: no legal edge for TIMEOUT cycles.
- `hall_fault` out 1: sticky fault flag (illegal code or skipped sector).

## Operation
- Sector map, forward order: code 5→0, 4→1, 6→2, 2→3, 3→4, 1→5. Codes 0 and 7 are illegal and map to sector 7.
- Filter: the synchronised code `s` is compared with `hall_code`.
  - When they differ, a candidate register and stability counter track `s`.
  - The counter restarts whenever `s` changes value.
  - `s` equal to `hall_code` cancels the candidate.
  - The candidate is accepted once it has been stable FILT_CYCLES consecutive cycles.
- `locked` is an internal flag, 0 after reset.
  - Acceptance of a legal code while unlocked sets `locked` and updates `sector`.
  - This acquisition produces no `edge_valid`, no `dir` change and no fault.
- While locked, on acceptance, compute delta = (new − old) mod 6:
  - Delta 1: `dir`=1 and `edge_valid` pulses.
  - Delta 5: `dir`=0 and `edge_valid` pulses.
  - Delta 2, 3 or 4: set `hall_fault`, no `edge_valid`, `dir` holds, `sector` updates, and the period reference is cleared.
  - Illegal code accepted: set `hall_fault`, `sector`=7, clear `locked` and the period reference.
- Period counter:
  - Counts every cycle and saturates at all-ones.
  - Resets to 1 on each legal edge (that edge's cycle counts as cycle 0).
  - On a legal edge with the reference valid, `period` is loaded with the counter value and `period_valid` pulses.
  - The first legal edge after reset, acquisition, fault or stall only sets the reference valid.
- Stall: when the counter reaches TIMEOUT, `stalled`=1, `period`=0 and the reference is cleared. The next legal edge clears `stalled`.
- `hall_fault` set and `fault_clr` in the same cycle: set wins.

## Timing
- Reset values:
  - `hall_code`=0, `sector`=7, `dir`=1.
  - `edge_valid`=0, `period`=0, `period_valid`=0.
  - `stalled`=0, `hall_fault`=0.
  - Counter=0, `locked`=0, reference invalid, synchroniser flops=0.
- Latency: a pin change held stable reaches `hall_code` exactly SYNC_STAGES+FILT_CYCLES clocks after the first sampling edge.
- `sector`, `dir`, `edge_valid`, `period`, `period_valid` and `hall_fault` update on that same clock edge. All outputs are registered.
- A glitch shorter than FILT_CYCLES cycles never changes any output.
- `rst_n` asserted mid-operation returns every output to its reset value immediately (asynchronous).

## Structure
- Shared package `hall_pkg`:
  - `SECTOR_INVALID` = 3'd7.
  - The code→sector lookup function.
  - Forward/reverse direction constants.
- Sub-module `hall_filter`: synchroniser plus stability counter on the 3-bit vector, parameterised by SYNC_STAGES and FILT_CYCLES. It outputs the accepted code and a one-cycle `accept` strobe.
- The top level holds the sector/direction logic, period counter, stall logic and fault logic.

## Test plan
Bench parameters: FILT_CYCLES=4, SYNC_STAGES=2, TIMEOUT=1000.
- Reset, then drive code 5 → after 6 clocks `hall_code`=5, `sector`=0, no `edge_valid`, `hall_fault`=0.
- Forward sequence 5,4,6,2,3,1, each held 200 cycles → `edge_valid` on each step and `dir`=1. The first step gives no `period_valid`; later steps give `period`=200.
- Reverse sequence 1,3,2 → `dir`=0 and `sector` goes 5,4,3.
- 3-cycle glitch 5→4→5 → no output change.
- Jump 5→6 (delta 2) → `hall_fault`=1, no `edge_valid`. `fault_clr` clears it; `fault_clr` coinciding with a new fault leaves `hall_fault`=1.
- Hold code 5 for 1000 cycles after an edge → `stalled`=1 and `period`=0. The next legal edge clears `stalled` without `period_valid`.
- Code 7 while locked → `sector`=7, `hall_fault`=1. A following legal code re-acquires with no `edge_valid`.
